// File: rtl/adder_tree8_pipe_pkg.sv
// Shared constants for the pipelined 8-input adder tree.
package adder_tree8_pipe_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned STAGES    = 3;

endpackage : adder_tree8_pipe_pkg

// File: rtl/add_reg_stage.sv
// Registered two-input modulo-2^WIDTH adder with synchronous active-high reset.
module add_reg_stage
    import adder_tree8_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;

    // Carry-out is dropped: the sum is kept at WIDTH bits.
    always_comb begin
        sum_d = WIDTH'(a + b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule : add_reg_stage

// File: rtl/adder_tree8_pipe.sv
// Three-stage pipelined 8-input adder tree; result appears three edges after capture.
module adder_tree8_pipe
    import adder_tree8_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    output logic [WIDTH-1:0] final_sum_reg
);

    logic [WIDTH-1:0] s0_reg;
    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] s3_reg;
    logic [WIDTH-1:0] p0_reg;
    logic [WIDTH-1:0] p1_reg;

    // Stage 1: pairwise operand sums.
    add_reg_stage #(.WIDTH(WIDTH)) u_s0 (.clk(clk), .rst(rst), .a(in0), .b(in1), .sum(s0_reg));
    add_reg_stage #(.WIDTH(WIDTH)) u_s1 (.clk(clk), .rst(rst), .a(in2), .b(in3), .sum(s1_reg));
    add_reg_stage #(.WIDTH(WIDTH)) u_s2 (.clk(clk), .rst(rst), .a(in4), .b(in5), .sum(s2_reg));
    add_reg_stage #(.WIDTH(WIDTH)) u_s3 (.clk(clk), .rst(rst), .a(in6), .b(in7), .sum(s3_reg));

    // Stage 2: quad sums.
    add_reg_stage #(.WIDTH(WIDTH)) u_p0 (.clk(clk), .rst(rst), .a(s0_reg), .b(s1_reg), .sum(p0_reg));
    add_reg_stage #(.WIDTH(WIDTH)) u_p1 (.clk(clk), .rst(rst), .a(s2_reg), .b(s3_reg), .sum(p1_reg));

    // Stage 3: final sum.
    add_reg_stage #(.WIDTH(WIDTH)) u_f (.clk(clk), .rst(rst), .a(p0_reg), .b(p1_reg), .sum(final_sum_reg));

endmodule : adder_tree8_pipe

// File: tb/tb_adder_tree8_pipe.sv
// Directed self-checking bench for adder_tree8_pipe with hand-computed sums.
module tb_adder_tree8_pipe;
    import adder_tree8_pipe_pkg::*;

    localparam int unsigned W = WIDTH_DEF;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_v [8];
    logic [W-1:0] final_sum_reg;

    int n_tests = 0;
    int n_fail  = 0;

    adder_tree8_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
        .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
        .final_sum_reg(final_sum_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Operand k = base + k*inc, truncated to W bits.
    task automatic set_in(input int base, input int inc);
        for (int k = 0; k < 8; k++) in_v[k] = W'(base + k * inc);
    endtask

    // One rising edge; returns at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Streaming rows: base, increment, expected sum mod 256.
    localparam int NROWS = 4;
    int row_base [NROWS] = '{10, 0, 5, 255};
    int row_inc  [NROWS] = '{10, 0, 5, 0};
    logic [W-1:0] row_exp [NROWS] = '{8'd104, 8'd0, 8'd180, 8'd248};

    initial begin
        rst = 1'b1;
        set_in(0, 0);
        @(negedge clk);
        step();
        check_eq("rst_s0", dut.s0_reg, 8'd0);
        check_eq("rst_s1", dut.s1_reg, 8'd0);
        check_eq("rst_s2", dut.s2_reg, 8'd0);
        check_eq("rst_s3", dut.s3_reg, 8'd0);
        check_eq("rst_p0", dut.p0_reg, 8'd0);
        check_eq("rst_p1", dut.p1_reg, 8'd0);
        check_eq("rst_final", final_sum_reg, 8'd0);
        rst = 1'b0;

        // Basic 1..8 followed by zeros, stage by stage.
        set_in(1, 1);
        step();
        check_eq("basic_s0", dut.s0_reg, 8'd3);
        check_eq("basic_s1", dut.s1_reg, 8'd7);
        check_eq("basic_s2", dut.s2_reg, 8'd11);
        check_eq("basic_s3", dut.s3_reg, 8'd15);
        check_eq("basic_final_e1", final_sum_reg, 8'd0);
        set_in(0, 0);
        step();
        check_eq("basic_p0", dut.p0_reg, 8'd10);
        check_eq("basic_p1", dut.p1_reg, 8'd26);
        check_eq("basic_final_e2", final_sum_reg, 8'd0);
        step();
        check_eq("basic_final_e3", final_sum_reg, 8'd36);

        // Back-to-back streaming; last row (all 255) is held to drain.
        for (int t = 0; t < NROWS + 2; t++) begin
            if (t < NROWS) set_in(row_base[t], row_inc[t]);
            step();
            if (t == 3) begin
                check_eq("wrap_s0", dut.s0_reg, 8'd254);
                check_eq("wrap_s3", dut.s3_reg, 8'd254);
            end
            if (t == 4) begin
                check_eq("wrap_p0", dut.p0_reg, 8'd252);
                check_eq("wrap_p1", dut.p1_reg, 8'd252);
            end
            if (t >= 2) check_eq($sformatf("stream_%0d", t - 2), final_sum_reg, row_exp[t - 2]);
        end
        for (int h = 0; h < 10; h++) begin
            step();
            check_eq($sformatf("hold_%0d", h), final_sum_reg, 8'd248);
        end

        // Mid-stream reset with two sets in flight.
        set_in(1, 1);
        step();
        set_in(10, 10);
        step();
        rst = 1'b1;
        set_in(5, 5);
        step();
        rst = 1'b0;
        check_eq("mrst_final_0", final_sum_reg, 8'd0);
        check_eq("mrst_p0", dut.p0_reg, 8'd0);
        check_eq("mrst_s0", dut.s0_reg, 8'd0);
        set_in(1, 0);
        step();
        check_eq("mrst_final_1", final_sum_reg, 8'd0);
        set_in(0, 0);
        step();
        check_eq("mrst_final_2", final_sum_reg, 8'd0);
        step();
        check_eq("mrst_first", final_sum_reg, 8'd8);
        step();
        check_eq("mrst_after", final_sum_reg, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adder_tree8_pipe
